// File: rtl/demux16_tdm_if.sv
// ---------------------------------------------------------------------------
// demux16_tdm_if
//   Bundles the serial receive link and the parallel frame outputs of
//   demux16_tdm.
//
//   Signals
//     din, din_valid, sof : serial side, driven by the upstream link (master)
//     out [0:15]          : last completed frame, out[k] = channel k
//     ch  [3:0]           : channel the next accepted bit will be written to
//     busy                : a frame is being collected
//     frame_valid         : one-cycle pulse, out has just been updated
//     frame_err           : one-cycle pulse, protocol error detected
//
//   Modports
//     master : link/consumer side (drives serial inputs, observes outputs)
//     slave  : demultiplexer side
// ---------------------------------------------------------------------------
interface demux16_tdm_if;
  logic        din;
  logic        din_valid;
  logic        sof;
  logic [0:15] out;
  logic [3:0]  ch;
  logic        busy;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    output din, din_valid, sof,
    input  out, ch, busy, frame_valid, frame_err
  );

  modport slave (
    input  din, din_valid, sof,
    output out, ch, busy, frame_valid, frame_err
  );
endinterface

// File: rtl/demux16_tdm.sv
// ---------------------------------------------------------------------------
// demux16_tdm
//   Serial-to-parallel time-division demultiplexer, the receive-side
//   counterpart of a 16:1 mux. Each accepted bit (din_valid=1) is steered into
//   the channel selected by an internal 4-bit counter; sof marks channel 0.
//   Once all 16 channels have arrived the collected shadow is published on
//   out together with a one-cycle frame_valid pulse. Partial frames never
//   reach out.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : demux16_tdm_if.slave (din, din_valid, sof in;
//             out, ch, busy, frame_valid, frame_err out)
//
//   Parameters
//     CLR_ON_SOF : 1 = shadow clears to 0 when a frame starts,
//                  0 = shadow keeps its previous contents
//
//   Build option
//     DEMUX16_PARITY_EN : when defined, each frame is followed by an
//       even-parity bit over the 16 data bits. A match publishes the frame,
//       a mismatch pulses frame_err and leaves out unchanged.
// ---------------------------------------------------------------------------
module demux16_tdm #(
  parameter bit CLR_ON_SOF = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  demux16_tdm_if.slave bus
);

`ifdef DEMUX16_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_e;
`endif

  state_e      state_q, state_d;
  logic [0:15] shadow_q, shadow_d;
  logic [0:15] out_q, out_d;
  logic [3:0]  ch_q, ch_d;
  logic        busy_q, busy_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;

  // Loads the current bit as channel 0 of a fresh frame (used from IDLE and
  // for an early-sof restart).
  function automatic logic [0:15] start_shadow(input logic [0:15] prev,
                                               input logic        bit_in);
    logic [0:15] s;
    s    = CLR_ON_SOF ? '0 : prev;
    s[0] = bit_in;
    return s;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so this block
    // stays purely combinational and never infers a latch.
    state_d       = state_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    ch_d          = ch_q;
    busy_d        = busy_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // din_valid=0 holds everything; gaps of any length are legal.
    if (bus.din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sof) begin
            shadow_d = start_shadow(shadow_q, bus.din);
            ch_d     = 4'd1;
            busy_d   = 1'b1;
            state_d  = COLLECT;
          end else begin
            // Stray bit outside a frame: drop it and flag it.
            frame_err_d = 1'b1;
          end
        end

        COLLECT: begin
          if (bus.sof) begin
            // Early sof: abandon the partial frame, restart on this bit.
            frame_err_d = 1'b1;
            shadow_d    = start_shadow(shadow_q, bus.din);
            ch_d        = 4'd1;
          end else begin
            shadow_d[ch_q] = bus.din;
            ch_d           = ch_q + 4'd1;   // wraps 15 -> 0
            if (ch_q == 4'd15) begin
`ifdef DEMUX16_PARITY_EN
              state_d = PARITY;
`else
              out_d         = shadow_d;
              frame_valid_d = 1'b1;
              busy_d        = 1'b0;
              state_d       = IDLE;
`endif
            end
          end
        end

`ifdef DEMUX16_PARITY_EN
        PARITY: begin
          if (bus.sof) begin
            frame_err_d = 1'b1;
            shadow_d    = start_shadow(shadow_q, bus.din);
            ch_d        = 4'd1;
            state_d     = COLLECT;
          end else begin
            // Even parity: the parity bit equals the XOR of the data bits.
            if (bus.din == (^shadow_q)) begin
              out_d         = shadow_q;
              frame_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
`endif

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ch_d    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      // NOTE: the shadow is an ordinary 16-bit register, so it is reset like
      // the rest; with CLR_ON_SOF=0 its reset value is visible in new frames.
      shadow_q      <= '0;
      out_q         <= '0;
      ch_q          <= 4'd0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      ch_q          <= ch_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.ch          = ch_q;
  assign bus.busy        = busy_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_demux16_tdm.sv
// ---------------------------------------------------------------------------
// tb_demux16_tdm
//   Directed self-checking bench for demux16_tdm. Inputs are driven 1 time
//   unit after a rising edge and outputs are sampled at the same point, so
//   each put() covers exactly one accepting edge. Pulses are also counted on
//   the falling edge to confirm totals.
//   Frame values are written MSB-first: bit 15 of a 16-bit literal is
//   channel 0 (out[0]).
// ---------------------------------------------------------------------------
module tb_demux16_tdm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux16_tdm_if bus ();

  demux16_tdm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && bus.frame_valid) fv_cnt++;
  end
  always @(negedge clk) begin
    if (rst_n && bus.frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid bit across one rising edge; valid is dropped afterwards.
  task automatic put(input logic d, input logic s);
    bus.din       = d;
    bus.sof       = s;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic put_parity(input logic [15:0] data);
`ifdef DEMUX16_PARITY_EN
    put(^data, 1'b0);
`else
    if (data === 16'hxxxx) $display("unused");
`endif
  endtask

  int gaps [16] = '{0, 3, 5, 1, 0, 2, 4, 0, 5, 1, 3, 0, 2, 5, 1, 4};

  // Full frame, sof on channel 0, optional idle gaps while checking that out
  // holds hold_val until the frame completes.
  task automatic send_frame(input logic [15:0] data, input bit use_gaps,
                            input logic [15:0] hold_val);
    for (int k = 0; k < 16; k++) begin
      if (use_gaps) begin
        for (int g = 0; g < gaps[k]; g++) begin
          tick();
          check("gap_hold", bus.out, hold_val);
        end
      end
      put(data[15-k], k == 0);
      if (use_gaps && k < 15) check("partial_hold", bus.out, hold_val);
    end
    put_parity(data);
  endtask

  int fv0, fe0;

  initial begin
    bus.din       = 1'b0;
    bus.sof       = 1'b0;
    bus.din_valid = 1'b0;

    // ---------------- reset state
    tick();
    tick();
    check("rst_out",  bus.out,         0);
    check("rst_ch",   bus.ch,          0);
    check("rst_busy", bus.busy,        0);
    check("rst_fv",   bus.frame_valid, 0);
    check("rst_fe",   bus.frame_err,   0);
    rst_n = 1'b1;

    // ---------------- first frame: 1 then fifteen 0s
    put(1'b1, 1'b1);
    check("f1_ch_after_sof",   bus.ch,   1);
    check("f1_busy_after_sof", bus.busy, 1);
    for (int k = 1; k < 16; k++) put(1'b0, 1'b0);
    put_parity(16'h8000);
    check("f1_out",  bus.out,         16'h8000);
    check("f1_fv",   bus.frame_valid, 1);
    check("f1_ch",   bus.ch,          0);
    check("f1_busy", bus.busy,        0);
    tick();
    check("f1_fv_one_cycle", bus.frame_valid, 0);

    // ---------------- walking one, back-to-back frames
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    for (int k = 0; k < 16; k++) begin
      send_frame(16'h8000 >> k, 1'b0, 16'h0);
      check($sformatf("walk_%0d", k), bus.out, 16'h8000 >> k);
    end
    tick();
    check("walk_fv_count", fv_cnt - fv0, 16);
    check("walk_fe_count", fe_cnt - fe0, 0);

    // ---------------- 0xA5C3 with idle gaps
    send_frame(16'hA5C3, 1'b1, 16'h0001);
    check("gaps_out", bus.out,         16'hA5C3);
    check("gaps_fv",  bus.frame_valid, 1);

    // ---------------- early sof after 7 bits, then 0xFFFF
    tick();
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    for (int k = 0; k < 7; k++) put(k[0], k == 0);
    check("early_ch7", bus.ch, 7);
    put(1'b1, 1'b1);
    check("early_fe",   bus.frame_err,   1);
    check("early_fv",   bus.frame_valid, 0);
    check("early_ch",   bus.ch,          1);
    check("early_hold", bus.out,         16'hA5C3);
    for (int k = 1; k < 16; k++) put(1'b1, 1'b0);
    put_parity(16'hFFFF);
    check("early_out", bus.out, 16'hFFFF);
    tick();
    check("early_fe_count", fe_cnt - fe0, 1);
    check("early_fv_count", fv_cnt - fv0, 1);

    // ---------------- stray bit in IDLE
    put(1'b1, 1'b0);
    check("stray_fe",   bus.frame_err, 1);
    check("stray_ch",   bus.ch,        0);
    check("stray_busy", bus.busy,      0);
    check("stray_out",  bus.out,       16'hFFFF);

    // ---------------- reset at bit 9
    tick();
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    for (int k = 0; k < 9; k++) put(1'b1, k == 0);
    check("mid_ch9", bus.ch, 9);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out",  bus.out,  0);
    check("mid_rst_ch",   bus.ch,   0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_no_fv", fv_cnt - fv0, 0);
    check("mid_rst_no_fe", fe_cnt - fe0, 0);
    check("mid_rst_idle",  bus.busy,     0);

    // ---------------- back-to-back distinct frames
    send_frame(16'h1234, 1'b0, 16'h0);
    check("b2b_a", bus.out, 16'h1234);
    send_frame(16'h8001, 1'b0, 16'h0);
    check("b2b_b",    bus.out,         16'h8001);
    check("b2b_b_fv", bus.frame_valid, 1);

`ifdef DEMUX16_PARITY_EN
    // ---------------- parity match / mismatch
    tick();
    for (int k = 0; k < 16; k++) put(k == 15, k == 0);
    check("par_state_ch", bus.ch, 0);
    check("par_busy",     bus.busy, 1);
    put(1'b1, 1'b0);
    check("par_ok_fv",  bus.frame_valid, 1);
    check("par_ok_out", bus.out,         16'h0001);
    for (int k = 0; k < 16; k++) put(k == 15, k == 0);
    put(1'b0, 1'b0);
    check("par_bad_fe",  bus.frame_err,   1);
    check("par_bad_fv",  bus.frame_valid, 0);
    check("par_bad_out", bus.out,         16'h0001);
    check("par_bad_idle", bus.busy,       0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux16_tdm.md
Name: demux16_tdm

Overview:
- Serial-to-parallel time-division demultiplexer: the receive-side counterpart of the 16:1 mux.
- The upstream mux serialises channel 0..15 onto one wire by stepping sel 0000..1111. This block steers each accepted bit into the matching output channel using an internal 4-bit channel counter.
- When all 16 channels have arrived, it presents them as one 16-bit frame.
- Sits at the far end of the serial link, feeding the 16-bit consumer.

Parameters:
- CLR_ON_SOF, 1: 1 = the frame shadow register clears to 0 when a new frame starts; 0 = the shadow keeps its previous contents.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle (one bit accepted per valid cycle).
- sof  input  1  start of frame; qualified by din_valid; marks din as channel 0.
- out  output  [0:15]  last completed frame; out[k] = channel k (out[0] = first bit after sof).
- ch  output  4  channel index the next accepted bit will be written to.
- busy  output  1  high while collecting a frame.
- frame_valid  output  1  one-cycle pulse: out has just been updated.
- frame_err  output  1  one-cycle pulse: a protocol error was detected.

Behaviour:
- Reset (async, rst_n=0): out=16'b0, ch=0, busy=0, frame_valid=0, frame_err=0, shadow=0, state=IDLE. Deassertion is used synchronously; the first accept is possible on the first rising edge with rst_n=1.
- States: IDLE, COLLECT (plus PARITY under the optional feature).
- IDLE, din_valid=1 and sof=1: shadow[0]=din (other bits 0 if CLR_ON_SOF=1), ch=1, busy=1, go to COLLECT.
- IDLE, din_valid=1 and sof=0: bit dropped, frame_err pulses next cycle, stay IDLE.
- COLLECT, din_valid=1 and sof=0: shadow[ch]=din, ch=ch+1.
  - If the bit was written to ch=15: next edge out=shadow with bit 15 = din, frame_valid=1 for one cycle, ch wraps to 0, busy=0, go to IDLE.
- COLLECT, din_valid=0: hold everything; no timeout, gaps of any length are allowed.
- COLLECT, din_valid=1 and sof=1 (early sof): frame_err pulses, the partial frame is discarded (out unchanged), and this bit restarts the frame as channel 0 (ch=1, stay in COLLECT).
- Latency: out and frame_valid update on the edge that accepts the 16th bit; both are visible in the following cycle.
- A back-to-back frame is allowed: sof on the cycle right after the 16th bit is accepted normally from IDLE.
- frame_valid and frame_err are never high in the same cycle except on a restart after error (err=1, valid=0).
- out is stable between frame_valid pulses; partial frames never appear on out.
- Reset mid-frame: everything returns to reset values immediately, the partial frame is lost, and no pulse is generated.

Optional Feature:
- Macro: DEMUX16_PARITY_EN.
- Defined:
  - After channel 15, go to PARITY instead of completing; the next valid bit is an even-parity bit over the 16 data bits.
  - Match: out updates and frame_valid pulses.
  - Mismatch: out unchanged and frame_err pulses.
  - Either way, return to IDLE.
  - sof in PARITY is treated as an early sof.
- Not defined: no PARITY state; frames are 16 bits as above.

Test Plan:
- Reset then a frame with sof on bit 0 and data sequence 1,0,0,…,0 (16 valid cycles) -> out=16'b1000000000000000 (out[0]=1), frame_valid one pulse, ch=0, busy=0.
- Walking-one: 16 frames, each with a single 1 at position k=0..15 -> out[k]=1 and all other bits 0 for each k; 16 frame_valid pulses; frame_err never asserts.
- Frame 0xA5C3 sent with random din_valid gaps of 0–5 cycles -> out=16'hA5C3 only after the 16th bit; out holds its previous value during the gaps.
- Early sof: sof after 7 bits, then a full frame of 0xFFFF -> one frame_err pulse at the restart, out=16'hFFFF, exactly one frame_valid.
- Stray bit in IDLE: din_valid=1, sof=0 -> frame_err pulse, ch stays 0, out unchanged. Separately, assert rst_n=0 at bit 9 -> out=0, ch=0, busy=0 with no pulse.
- DEMUX16_PARITY_EN: frame 0x0001 followed by parity bit 1 -> frame_valid; the same frame with parity bit 0 -> frame_err and out unchanged.
